// File: rtl/wb_flash_cache.sv
// -----------------------------------------------------------------------------
// wb_flash_cache
//
// Read-only, direct-mapped line cache between a CPU Wishbone slave port and a
// QSPI flash controller's Wishbone master port. A read miss fetches one whole
// line from flash as a strictly sequential burst, so the flash controller can
// keep chip-select asserted for all beats. Writes are acknowledged and dropped.
//
// Ports
//   wb_clk_i, wb_reset_i    clock (rising edge) and async active-high reset
//   wb_adr_i  [AW-1:0]      CPU word address
//   wb_dat_i  [DW-1:0]      CPU write data (ignored, flash is read-only)
//   wb_dat_o  [DW-1:0]      registered read data, held between acks
//   wb_we_i, wb_sel_i       CPU write enable / byte selects
//   wb_stb_i, wb_cyc_i      CPU strobes
//   wb_ack_o                one-cycle acknowledge
//   m_adr_o   [AW-1:0]      flash word address (advances once per beat)
//   m_dat_i   [DW-1:0]      flash read data
//   m_cyc_o, m_stb_o        flash strobes, held for the whole line fill
//   m_we_o                  always 0
//   m_ack_i                 flash acknowledge, one per beat
//   flush_i                 invalidate every line
// -----------------------------------------------------------------------------
module wb_flash_cache #(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_we_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  output logic [AW-1:0]   m_adr_o,
  input  logic [DW-1:0]   m_dat_i,
  output logic            m_cyc_o,
  output logic            m_stb_o,
  output logic            m_we_o,
  input  logic            m_ack_i,
  input  logic            flush_i
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int ENT_W = IDX_W + OFF_W;
  localparam int TAG_W = AW - ENT_W;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // State
  logic [1:0]       state_q,      state_d;
  logic [LINES-1:0] valid_q,      valid_d;
  logic [AW-1:0]    req_adr_q,    req_adr_d;   // address of the miss being filled
  logic [OFF_W-1:0] beat_q,       beat_d;      // word k of the line being filled
  logic             m_cyc_q,      m_cyc_d;
  logic [AW-1:0]    m_adr_q,      m_adr_d;
  logic             wb_ack_q,     wb_ack_d;
  logic [DW-1:0]    wb_dat_q,     wb_dat_d;
  logic             flush_pend_q, flush_pend_d; // flush seen while busy
  logic             abort_q,      abort_d;      // CPU left the cycle mid-fill

  // Line storage
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [DW-1:0]    data_mem [LINES*LINE_WORDS];
  logic             tag_we;
  logic             data_we;

  // Address fields of the incoming request and of the line being filled
  logic [OFF_W-1:0] s_off, r_off;
  logic [IDX_W-1:0] s_idx, r_idx;
  logic [TAG_W-1:0] s_tag, r_tag;
  logic             slave_req;
  logic             hit;
  logic [DW-1:0]    fill_word;

  assign s_off = wb_adr_i[OFF_W-1:0];
  assign s_idx = wb_adr_i[ENT_W-1:OFF_W];
  assign s_tag = wb_adr_i[AW-1:ENT_W];
  assign r_off = req_adr_q[OFF_W-1:0];
  assign r_idx = req_adr_q[ENT_W-1:OFF_W];
  assign r_tag = req_adr_q[AW-1:ENT_W];

  // The registered ack gates re-sampling, so a held strobe is not seen twice.
  assign slave_req = wb_cyc_i & wb_stb_i & ~wb_ack_q;
  assign hit       = valid_q[s_idx] && (tag_mem[s_idx] == s_tag);

  // On the last beat the requested word is either arriving now or already in
  // the line, so the response needs no extra cycle.
  assign fill_word = (r_off == LAST_BEAT) ? m_dat_i : data_mem[{r_idx, r_off}];

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d      = state_q;
    valid_d      = valid_q;
    req_adr_d    = req_adr_q;
    beat_d       = beat_q;
    m_cyc_d      = m_cyc_q;
    m_adr_d      = m_adr_q;
    wb_ack_d     = 1'b0;
    wb_dat_d     = wb_dat_q;
    flush_pend_d = flush_pend_q;
    abort_d      = abort_q;
    tag_we       = 1'b0;
    data_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush_i) valid_d = '0;
        if (slave_req) begin
          if (wb_we_i) begin
            wb_ack_d = 1'b1;
          end else if (hit && !flush_i) begin
            wb_ack_d = 1'b1;
            wb_dat_d = data_mem[{s_idx, s_off}];
          end else begin
            // A flush in the same cycle forces the miss path.
            state_d        = S_FILL;
            req_adr_d      = wb_adr_i;
            beat_d         = '0;
            m_cyc_d        = 1'b1;
            m_adr_d        = {s_tag, s_idx, {OFF_W{1'b0}}};
            abort_d        = 1'b0;
            // Line contents are about to be overwritten beat by beat.
            valid_d[s_idx] = 1'b0;
          end
        end
      end

      S_FILL: begin
        if (flush_i)   flush_pend_d = 1'b1;
        if (!wb_cyc_i) abort_d      = 1'b1;
        if (m_ack_i) begin
          data_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            m_cyc_d        = 1'b0;
            tag_we         = 1'b1;
            valid_d[r_idx] = 1'b1;
            state_d        = S_RESP;
            // An abandoned request still fills the line but gets no ack.
            if (!abort_q && wb_cyc_i) begin
              wb_ack_d = 1'b1;
              wb_dat_d = fill_word;
            end
          end else begin
            beat_d  = beat_q + 1'b1;
            m_adr_d = m_adr_q + 1'b1;
          end
        end
      end

      S_RESP: begin
        // wb_ack_o is high during this cycle; a deferred flush also drops
        // the line that was just filled.
        state_d = S_IDLE;
        if (flush_pend_q || flush_i) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      req_adr_q    <= '0;
      beat_q       <= '0;
      m_cyc_q      <= 1'b0;
      m_adr_q      <= '0;
      wb_ack_q     <= 1'b0;
      wb_dat_q     <= '0;
      flush_pend_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      req_adr_q    <= req_adr_d;
      beat_q       <= beat_d;
      m_cyc_q      <= m_cyc_d;
      m_adr_q      <= m_adr_d;
      wb_ack_q     <= wb_ack_d;
      wb_dat_q     <= wb_dat_d;
      flush_pend_q <= flush_pend_d;
      abort_q      <= abort_d;
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits alone decide
  // whether their contents mean anything, and leaving them unreset lets
  // them map onto RAM.
  always_ff @(posedge wb_clk_i) begin
    if (tag_we)  tag_mem[r_idx]             <= r_tag;
    if (data_we) data_mem[{r_idx, beat_q}]  <= m_dat_i;
  end

  assign wb_ack_o = wb_ack_q;
  assign wb_dat_o = wb_dat_q;
  assign m_adr_o  = m_adr_q;
  assign m_cyc_o  = m_cyc_q;
  assign m_stb_o  = m_cyc_q;
  assign m_we_o   = 1'b0;

  // Write data and byte selects have no effect on a read-only cache.
  logic unused_ok;
  assign unused_ok = ^{wb_dat_i, wb_sel_i};

endmodule

// File: tb/tb_wb_flash_cache.sv
// -----------------------------------------------------------------------------
// tb_wb_flash_cache
//
// Drives CPU reads/writes on the slave port and models the flash controller
// on the master port with a random per-beat ack latency. Expected burst
// addresses and read data are queued when a request is issued and popped as
// the design answers.
// -----------------------------------------------------------------------------
module tb_wb_flash_cache;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] wb_adr_i = '0;
  logic [DW-1:0] wb_dat_i = '0;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_i = 1'b0;
  logic [3:0]    wb_sel_i = 4'hF;
  logic          wb_stb_i = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_ack_o;
  logic [AW-1:0] m_adr_o;
  logic [DW-1:0] m_dat_i = '0;
  logic          m_cyc_o;
  logic          m_stb_o;
  logic          m_we_o;
  logic          m_ack_i = 1'b0;
  logic          flush_i = 1'b0;

  wb_flash_cache #(.AW(AW), .DW(DW), .LINES(16), .LINE_WORDS(LW)) dut (
    .wb_clk_i  (clk),
    .wb_reset_i(rst),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_we_i   (wb_we_i),
    .wb_sel_i  (wb_sel_i),
    .wb_stb_i  (wb_stb_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_ack_o  (wb_ack_o),
    .m_adr_o   (m_adr_o),
    .m_dat_i   (m_dat_i),
    .m_cyc_o   (m_cyc_o),
    .m_stb_o   (m_stb_o),
    .m_we_o    (m_we_o),
    .m_ack_i   (m_ack_i),
    .flush_i   (flush_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int beats_seen = 0;
  int last_mack_cyc = 0;

  logic [31:0] exp_beat_q[$];
  logic [31:0] exp_dat_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flash_word(input logic [31:0] a);
    return {a[7:0] ^ 8'hA5, a[23:0]};
  endfunction

  // Flash controller model: acks each beat after 0..2 idle cycles and checks
  // that the burst address is the next one expected.
  initial begin
    int  wait_left;
    bit  active;
    logic [31:0] e;
    wait_left = 0;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (m_cyc_o && m_stb_o && !rst) begin
        if (!active) begin
          active = 1'b1;
          wait_left = $urandom_range(0, 2);
        end
        if (wait_left == 0) begin
          e = (exp_beat_q.size() > 0) ? exp_beat_q.pop_front() : 32'hDEAD_BEEF;
          check("beat_adr", 32'(m_adr_o), e);
          m_ack_i = 1'b1;
          m_dat_i = flash_word(32'(m_adr_o));
          beats_seen++;
          last_mack_cyc = cyc_cnt;
          active = 1'b0;
        end else begin
          m_ack_i = 1'b0;
          wait_left--;
        end
      end else begin
        m_ack_i = 1'b0;
        active = 1'b0;
      end
    end
  end

  task automatic push_line(input logic [31:0] a);
    for (int k = 0; k < LW; k++) exp_beat_q.push_back({a[31:2], 2'b00} + 32'(k));
  endtask

  // Read with optional flush: flush_req raises flush_i together with the
  // request, flush_at > 0 pulses it during that cycle of the wait.
  task automatic wb_read(input logic [31:0] a, input bit miss, input bit flush_req, input int flush_at);
    int b0, n;
    bit got;
    b0 = beats_seen;
    if (miss) push_line(a);
    exp_dat_q.push_back(flash_word(a));
    wb_adr_i = a[AW-1:0];
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    flush_i  = flush_req;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk); #1;
      n++;
      flush_i = (n == flush_at);
      if (wb_ack_o) got = 1'b1;
    end
    check("rd_ack_seen", 32'(got), 32'd1);
    if (got) begin
      check("rd_data", wb_dat_o, exp_dat_q.pop_front());
      if (miss) check("miss_lat", 32'(cyc_cnt), 32'(last_mack_cyc + 1));
      else      check("hit_lat", 32'(n), 32'd1);
    end else begin
      exp_dat_q.delete();
    end
    check(miss ? "miss_beats" : "hit_beats", 32'(beats_seen - b0), miss ? 32'(LW) : 32'd0);
    check("beat_q_left", 32'(exp_beat_q.size()), 32'd0);
    exp_beat_q.delete();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    flush_i  = 1'b0;
    @(negedge clk); #1;
    check("ack_one_cycle", 32'(wb_ack_o), 32'd0);
    check("dat_hold", wb_dat_o, flash_word(a));
  endtask

  task automatic wb_write(input logic [31:0] a);
    int b0, n;
    bit got;
    b0 = beats_seen;
    wb_adr_i = a[AW-1:0];
    wb_dat_i = 32'h1234_5678;
    wb_we_i  = 1'b1;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk); #1;
      n++;
      if (wb_ack_o) got = 1'b1;
    end
    check("wr_ack_seen", 32'(got), 32'd1);
    check("wr_lat", 32'(n), 32'd1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(negedge clk); #1;
    check("wr_ack_one_cycle", 32'(wb_ack_o), 32'd0);
    check("wr_no_master", 32'(beats_seen - b0), 32'd0);
  endtask

  // CPU abandons the cycle after the first beat: the fill must finish
  // without acking, leaving the line valid.
  task automatic wb_read_abort(input logic [31:0] a);
    int b0, n, acks;
    b0 = beats_seen;
    push_line(a);
    wb_adr_i = a[AW-1:0];
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    n = 0;
    while (beats_seen == b0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (wb_ack_o) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_beats", 32'(beats_seen - b0), 32'(LW));
    exp_beat_q.delete();
  endtask

  // Reset lands while the second beat is outstanding.
  task automatic reset_mid_fill(input logic [31:0] a);
    int b0, n;
    b0 = beats_seen;
    push_line(a);
    wb_adr_i = a[AW-1:0];
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    n = 0;
    while (beats_seen == b0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk); #1;
    check("pre_rst_cyc", 32'(m_cyc_o), 32'd1);
    check("pre_rst_adr", 32'(m_adr_o), {a[31:2], 2'b00} + 32'd1);
    rst = 1'b1;
    #1;
    check("rst_cyc_async", 32'(m_cyc_o), 32'd0);
    check("rst_stb_async", 32'(m_stb_o), 32'd0);
    check("rst_adr", 32'(m_adr_o), 32'd0);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    exp_beat_q.delete();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_ack", 32'(wb_ack_o), 32'd0);
    check("reset_cyc", 32'(m_cyc_o), 32'd0);
    check("reset_stb", 32'(m_stb_o), 32'd0);
    check("reset_adr", 32'(m_adr_o), 32'd0);
    check("reset_dat", wb_dat_o, 32'd0);
    check("reset_we", 32'(m_we_o), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Cold miss, then hits in the same line
    wb_read(32'h000005, 1'b1, 1'b0, 0);
    wb_read(32'h000006, 1'b0, 1'b0, 0);
    wb_read(32'h000007, 1'b0, 1'b0, 0);
    wb_read(32'h000004, 1'b0, 1'b0, 0);

    // Conflict on the same index evicts
    wb_read(32'h000046, 1'b1, 1'b0, 0);
    wb_read(32'h000005, 1'b1, 1'b0, 0);
    wb_read(32'h000021, 1'b1, 1'b0, 0);
    wb_read(32'h000022, 1'b0, 1'b0, 0);

    // Write: acked, no flash traffic, no allocation, contents unchanged
    wb_write(32'h000010);
    wb_read(32'h000006, 1'b0, 1'b0, 0);
    wb_read(32'h000010, 1'b1, 1'b0, 0);

    // Flush during a fill: fill completes and acks, then everything misses
    wb_read(32'h000088, 1'b1, 1'b0, 2);
    wb_read(32'h000088, 1'b1, 1'b0, 0);
    wb_read(32'h000006, 1'b1, 1'b0, 0);

    // Flush together with a request that would hit is treated as a miss
    wb_read(32'h000006, 1'b1, 1'b1, 0);
    wb_read(32'h000007, 1'b0, 1'b0, 0);

    // CPU drops the cycle mid-fill: no ack, line still becomes valid
    wb_read_abort(32'h000030);
    wb_read(32'h000031, 1'b0, 1'b0, 0);

    // Reset mid-fill: nothing valid afterwards
    reset_mid_fill(32'h000045);
    wb_read(32'h000045, 1'b1, 1'b0, 0);
    wb_read(32'h000006, 1'b1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
